// File: rtl/lt24_pkg.sv
// rtl/lt24_pkg.sv - shared display geometry, colours and arbiter state encodings
package lt24_pkg;

  localparam int LT24_WIDTH      = 240;
  localparam int LT24_HEIGHT     = 320;
  localparam int LT24_MAX_STREAK = 4;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Unsigned, non-wrapping bounds check of a pixel coordinate.
  function automatic logic pixel_in_range(input logic [7:0] x, input logic [8:0] y,
                                          input int width, input int height);
    return (32'(x) < 32'(width)) && (32'(y) < 32'(height));
  endfunction

endpackage

// File: rtl/lt24_pixel_reg.sv
// rtl/lt24_pixel_reg.sv - single-entry registered pixel output stage
module lt24_pixel_reg
  import lt24_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [7:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_valid,
  output logic [7:0]  o_x,
  output logic [8:0]  o_y,
  output logic [15:0] o_data,
  input  logic        i_ready
);

  logic        r_valid;
  logic [7:0]  r_x;
  logic [8:0]  r_y;
  logic [15:0] r_data;

  // The entry can take a new pixel when empty or when it drains this cycle,
  // which is what lets a burst stream at one pixel per clock.
  assign o_ready = ~r_valid | i_ready;

  // Load on accept, otherwise empty once the display takes the pixel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_x     <= i_x;
      r_y     <= i_y;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_data  = r_data;

endmodule

// File: rtl/lt24_pixel_arbiter.sv
// rtl/lt24_pixel_arbiter.sv - burst arbiter sharing the LT24 pixel port between two renderers
module lt24_pixel_arbiter
  import lt24_pkg::*;
#(
  parameter int WIDTH      = LT24_WIDTH,
  parameter int HEIGHT     = LT24_HEIGHT,
  parameter int MAX_STREAK = LT24_MAX_STREAK
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        displayBusy,
  input  logic [1:0]  reqValid,
  input  logic [1:0]  reqLast,
  input  logic [15:0] reqX,
  input  logic [17:0] reqY,
  input  logic [31:0] reqData,
  output logic [1:0]  reqReady,
  output logic [1:0]  grant,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic [7:0]  dropCount
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic [SW-1:0] r_streak;
  logic [7:0]  r_drop_count;

  logic        w_sel1;
  logic [7:0]  w_beat_x;
  logic [8:0]  w_beat_y;
  logic [15:0] w_beat_data;
  logic        w_beat_last;
  logic        w_can_load;
  logic        w_accept;
  logic        w_in_range;
  logic        w_load;

  // Mux the granted port's beat onto a single path.
  assign w_sel1      = (r_state == OWN1);
  assign w_beat_x    = w_sel1 ? reqX[15:8]     : reqX[7:0];
  assign w_beat_y    = w_sel1 ? reqY[17:9]     : reqY[8:0];
  assign w_beat_data = w_sel1 ? reqData[31:16] : reqData[15:0];
  assign w_beat_last = w_sel1 ? reqLast[1]     : reqLast[0];

  assign reqReady   = grant & {2{w_can_load & ~displayBusy}};
  assign w_accept   = |(reqValid & reqReady);
  assign w_in_range = pixel_in_range(w_beat_x, w_beat_y, WIDTH, HEIGHT);
  assign w_load     = w_accept & w_in_range;

  // State register; the grant is decoded from it so it is effectively registered.
  always_ff @(posedge clock) begin
    if (!globalReset) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  // Next-state: port 1 wins ties until it has starved port 0 for MAX_STREAK bursts.
  always_comb begin
    w_next_state = r_state;
    if (displayBusy) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (reqValid[1] && ((r_streak < SW'(MAX_STREAK)) || !reqValid[0]))
            w_next_state = OWN1;
          else if (reqValid[0])
            w_next_state = OWN0;
        end
        OWN0, OWN1: begin
          if (w_accept && w_beat_last) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Output decode: one-hot grant for the owning port.
  always_comb begin
    grant = 2'b00;
    case (r_state)
      OWN0:    grant = 2'b01;
      OWN1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Count how many port-1 bursts in a row were granted over a waiting port 0.
  always_ff @(posedge clock) begin
    if (!globalReset) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (!reqValid[0])
        r_streak <= '0;
      else if (w_next_state == OWN0)
        r_streak <= '0;
      else if ((w_next_state == OWN1) && (r_streak < SW'(MAX_STREAK)))
        r_streak <= r_streak + 1'b1;
    end
  end

  // Saturating count of accepted beats that fell outside the panel.
  always_ff @(posedge clock) begin
    if (!globalReset)
      r_drop_count <= '0;
    else if (w_accept && !w_in_range && (r_drop_count != 8'hFF))
      r_drop_count <= r_drop_count + 8'd1;
  end

  assign dropCount = r_drop_count;

  lt24_pixel_reg u_pixel_reg (
    .clk     (clock),
    .resetn  (globalReset),
    .i_flush (displayBusy),
    .i_valid (w_load),
    .i_x     (w_beat_x),
    .i_y     (w_beat_y),
    .i_data  (w_beat_data),
    .o_ready (w_can_load),
    .o_valid (pixelWrite),
    .o_x     (xAddr),
    .o_y     (yAddr),
    .o_data  (pixelData),
    .i_ready (pixelReady)
  );

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// tb/tb_lt24_pixel_arbiter.sv - directed self-checking bench for lt24_pixel_arbiter
module tb_lt24_pixel_arbiter;

  logic        clock = 1'b0;
  logic        globalReset;
  logic        displayBusy;
  logic [1:0]  reqValid;
  logic [1:0]  reqLast;
  logic [15:0] reqX;
  logic [17:0] reqY;
  logic [31:0] reqData;
  logic [1:0]  reqReady;
  logic [1:0]  grant;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic [7:0]  dropCount;

  int errors = 0;
  int checks = 0;

  lt24_pixel_arbiter dut (
    .clock       (clock),
    .globalReset (globalReset),
    .displayBusy (displayBusy),
    .reqValid    (reqValid),
    .reqLast     (reqLast),
    .reqX        (reqX),
    .reqY        (reqY),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .grant       (grant),
    .xAddr       (xAddr),
    .yAddr       (yAddr),
    .pixelData   (pixelData),
    .pixelWrite  (pixelWrite),
    .pixelReady  (pixelReady),
    .dropCount   (dropCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int n, input logic v, input logic last,
                          input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
    reqValid[n]        = v;
    reqLast[n]         = last;
    reqX[n*8 +: 8]     = x;
    reqY[n*9 +: 9]     = y;
    reqData[n*16 +: 16] = d;
  endtask

  initial begin
    globalReset = 1'b0;
    displayBusy = 1'b0;
    pixelReady  = 1'b1;
    reqValid = '0; reqLast = '0; reqX = '0; reqY = '0; reqData = '0;
    next_cycle();
    next_cycle();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_pw", 32'(pixelWrite), 32'h0);
    chk("rst_x", 32'(xAddr), 32'h0);
    chk("rst_y", 32'(yAddr), 32'h0);
    chk("rst_data", 32'(pixelData), 32'h0);
    chk("rst_drop", 32'(dropCount), 32'h0);
    chk("rst_ready", 32'(reqReady), 32'h0);
    globalReset = 1'b1;
    next_cycle();

    // 1: port 0 burst of four green pixels along row 0
    set_port(0, 1'b1, 1'b0, 8'd0, 9'd0, 16'h07E0);
    #1 chk("t1_idle_ready", 32'(reqReady), 32'h0);
    next_cycle();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ready", 32'(reqReady), 32'h1);
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, (i == 3), 8'(i), 9'd0, 16'h07E0);
      next_cycle();
      chk("t1_pw", 32'(pixelWrite), 32'h1);
      chk("t1_x", 32'(xAddr), 32'(i));
      chk("t1_data", 32'(pixelData), 32'h07E0);
    end
    chk("t1_grant_end", 32'(grant), 32'h0);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();
    chk("t1_pw_end", 32'(pixelWrite), 32'h0);

    // 2: both ports in IDLE with streak 0 -> port 1 first, then one idle cycle
    set_port(0, 1'b1, 1'b1, 8'd10, 9'd0, 16'h000A);
    set_port(1, 1'b1, 1'b1, 8'd20, 9'd5, 16'hF800);
    next_cycle();
    chk("t2_grant1", 32'(grant), 32'h2);
    next_cycle();
    chk("t2_idle_gap", 32'(grant), 32'h0);
    chk("t2_p1_x", 32'(xAddr), 32'd20);
    chk("t2_p1_y", 32'(yAddr), 32'd5);
    chk("t2_p1_data", 32'(pixelData), 32'hF800);
    set_port(1, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();
    chk("t2_grant0", 32'(grant), 32'h1);
    next_cycle();
    chk("t2_p0_x", 32'(xAddr), 32'd10);
    chk("t2_grant_end", 32'(grant), 32'h0);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();

    // 3: port 1 keeps requesting while port 0 waits; fifth grant goes to port 0
    set_port(0, 1'b1, 1'b1, 8'd30, 9'd0, 16'h1111);
    set_port(1, 1'b1, 1'b1, 8'd31, 9'd0, 16'h2222);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      chk("t3_grant_p1", 32'(grant), 32'h2);
      next_cycle();
      chk("t3_gap", 32'(grant), 32'h0);
    end
    next_cycle();
    chk("t3_grant_p0", 32'(grant), 32'h1);
    set_port(1, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();
    chk("t3_p0_x", 32'(xAddr), 32'd30);
    chk("t3_p0_data", 32'(pixelData), 32'h1111);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();

    // 4: pixelReady stalls for three cycles in the middle of a burst
    set_port(0, 1'b1, 1'b0, 8'd50, 9'd7, 16'h1032);
    next_cycle();
    next_cycle();
    chk("t4_x50", 32'(xAddr), 32'd50);
    set_port(0, 1'b1, 1'b0, 8'd51, 9'd7, 16'h1033);
    next_cycle();
    chk("t4_x51", 32'(xAddr), 32'd51);
    pixelReady = 1'b0;
    set_port(0, 1'b1, 1'b0, 8'd52, 9'd7, 16'h1034);
    #1 chk("t4_stall_ready", 32'(reqReady), 32'h0);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      chk("t4_hold_pw", 32'(pixelWrite), 32'h1);
      chk("t4_hold_x", 32'(xAddr), 32'd51);
      chk("t4_hold_y", 32'(yAddr), 32'd7);
      chk("t4_hold_data", 32'(pixelData), 32'h1033);
      #1 chk("t4_hold_ready", 32'(reqReady), 32'h0);
    end
    pixelReady = 1'b1;
    #1 chk("t4_resume_ready", 32'(reqReady), 32'h1);
    next_cycle();
    chk("t4_x52", 32'(xAddr), 32'd52);
    chk("t4_d52", 32'(pixelData), 32'h1034);
    set_port(0, 1'b1, 1'b1, 8'd53, 9'd7, 16'h1035);
    next_cycle();
    chk("t4_x53", 32'(xAddr), 32'd53);
    chk("t4_grant_end", 32'(grant), 32'h0);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();
    chk("t4_drained", 32'(pixelWrite), 32'h0);

    // 5: out-of-range beats are dropped and counted, edge pixel is written
    set_port(0, 1'b1, 1'b0, 8'd240, 9'd10, 16'hFFFF);
    next_cycle();
    next_cycle();
    chk("t5_drop_x_pw", 32'(pixelWrite), 32'h0);
    chk("t5_drop_x_cnt", 32'(dropCount), 32'd1);
    set_port(0, 1'b1, 1'b0, 8'd0, 9'd320, 16'hFFFF);
    next_cycle();
    chk("t5_drop_y_pw", 32'(pixelWrite), 32'h0);
    chk("t5_drop_y_cnt", 32'(dropCount), 32'd2);
    set_port(0, 1'b1, 1'b1, 8'd239, 9'd319, 16'h001F);
    next_cycle();
    chk("t5_edge_pw", 32'(pixelWrite), 32'h1);
    chk("t5_edge_x", 32'(xAddr), 32'd239);
    chk("t5_edge_y", 32'(yAddr), 32'd319);
    chk("t5_edge_cnt", 32'(dropCount), 32'd2);
    chk("t5_grant_end", 32'(grant), 32'h0);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();

    // 6a: reset in the middle of a burst
    set_port(0, 1'b1, 1'b0, 8'd60, 9'd2, 16'hAAAA);
    next_cycle();
    next_cycle();
    chk("t6a_pre_pw", 32'(pixelWrite), 32'h1);
    globalReset = 1'b0;
    next_cycle();
    chk("t6a_grant", 32'(grant), 32'h0);
    chk("t6a_pw", 32'(pixelWrite), 32'h0);
    chk("t6a_drop", 32'(dropCount), 32'h0);
    chk("t6a_ready", 32'(reqReady), 32'h0);
    globalReset = 1'b1;
    set_port(0, 1'b1, 1'b1, 8'd70, 9'd2, 16'hBBBB);
    next_cycle();
    chk("t6a_regrant", 32'(grant), 32'h1);
    next_cycle();
    chk("t6a_x70", 32'(xAddr), 32'd70);
    chk("t6a_d70", 32'(pixelData), 32'hBBBB);
    set_port(0, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();

    // 6b: display goes busy in the middle of a port 1 burst
    set_port(1, 1'b1, 1'b0, 8'd80, 9'd1, 16'hCCCC);
    next_cycle();
    next_cycle();
    chk("t6b_pre_pw", 32'(pixelWrite), 32'h1);
    displayBusy = 1'b1;
    #1 chk("t6b_busy_ready", 32'(reqReady), 32'h0);
    next_cycle();
    chk("t6b_grant", 32'(grant), 32'h0);
    chk("t6b_pw", 32'(pixelWrite), 32'h0);
    next_cycle();
    chk("t6b_no_grant", 32'(grant), 32'h0);
    displayBusy = 1'b0;
    next_cycle();
    chk("t6b_regrant", 32'(grant), 32'h2);
    set_port(1, 1'b1, 1'b1, 8'd81, 9'd1, 16'hDDDD);
    next_cycle();
    chk("t6b_x81", 32'(xAddr), 32'd81);
    chk("t6b_pw81", 32'(pixelWrite), 32'h1);
    chk("t6b_grant_end", 32'(grant), 32'h0);
    set_port(1, 1'b0, 1'b0, 8'd0, 9'd0, 16'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
